// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: drives one PE MAC job over the pe_cmd bus.
// Sequence: RESET, SET_CONV_MODE, optional LOAD_DATA, conv_len TRIGGERs,
// then waits for the PE to drain and captures its mac_value.
module pe_mac_sequencer #(
    parameter int ACLEN      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DRAIN_TMO  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  conv_len_i,
    input  logic                  preload_en_i,
    input  logic [DATA_WIDTH-1:0] preload_i,
    input  logic                  abort_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [DATA_WIDTH-1:0] op_data_i,
    input  logic [DATA_WIDTH-1:0] op_weight_i,
    output logic                  pe_cmd_valid_o,
    output logic [ACLEN:0]        pe_cmd_o,
    output logic [DATA_WIDTH-1:0] pe_param1_o,
    output logic [DATA_WIDTH-1:0] pe_preload_o,
    output logic [DATA_WIDTH-1:0] pe_data_o,
    output logic [DATA_WIDTH-1:0] pe_weight_o,
    input  logic                  pe_busy_i,
    input  logic [DATA_WIDTH-1:0] pe_mac_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  idle_o
);

    localparam int TMO_W = $clog2(DRAIN_TMO + 1);

    localparam logic [ACLEN:0] CMD_RESET     = (ACLEN+1)'(0);
    localparam logic [ACLEN:0] CMD_TRIGGER   = (ACLEN+1)'(1);
    localparam logic [ACLEN:0] CMD_LOAD_DATA = (ACLEN+1)'(5);
    localparam logic [ACLEN:0] CMD_SET_CONV  = (ACLEN+1)'(6);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CFG,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]  len_q;
    logic                  preload_en_q;
    logic [DATA_WIDTH-1:0] preload_q;
    logic [LEN_WIDTH-1:0]  term_q;
    logic                  seen_busy_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  err_q;

    logic           go_start;
    logic           accept;
    logic           drain_ok;
    logic           tmo_hit;
    logic           cmd_valid;
    logic [ACLEN:0] cmd;
    logic           ready;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, PE command and handshake decode
    always_comb begin
        state_d   = state_q;
        go_start  = 1'b0;
        accept    = 1'b0;
        drain_ok  = 1'b0;
        tmo_hit   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = CMD_RESET;
        ready     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    go_start = 1'b1;
                    state_d  = (conv_len_i == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                cmd_valid = 1'b1;
                cmd       = CMD_RESET;
                state_d   = S_CFG;
            end
            S_CFG: begin
                cmd_valid = 1'b1;
                cmd       = CMD_SET_CONV;
                state_d   = preload_en_q ? S_LOAD : S_FEED;
            end
            S_LOAD: begin
                cmd_valid = 1'b1;
                cmd       = CMD_LOAD_DATA;
                state_d   = S_FEED;
            end
            S_FEED: begin
                ready = 1'b1;
                if (op_valid_i) begin
                    accept    = 1'b1;
                    cmd_valid = 1'b1;
                    cmd       = CMD_TRIGGER;
                    if (term_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!pe_busy_i && seen_busy_q) begin
                    drain_ok = 1'b1;
                    state_d  = S_DONE;
                end else if (tmo_q == TMO_W'(DRAIN_TMO - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides whatever the active state decoded, including a
        // same-cycle operand handshake, which is therefore not consumed.
        if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_DONE;
            accept    = 1'b0;
            drain_ok  = 1'b0;
            tmo_hit   = 1'b0;
            ready     = 1'b0;
            cmd_valid = 1'b1;
            cmd       = CMD_RESET;
        end
    end

    // Job context, term/timeout counters, result capture and error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q        <= '0;
            preload_en_q <= 1'b0;
            preload_q    <= '0;
            term_q       <= '0;
            seen_busy_q  <= 1'b0;
            tmo_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            if (go_start) begin
                len_q        <= conv_len_i;
                preload_en_q <= preload_en_i;
                preload_q    <= preload_i;
                term_q       <= '0;
                seen_busy_q  <= 1'b0;
                tmo_q        <= '0;
                err_q        <= (conv_len_i == '0);
            end else begin
                if (accept) begin
                    term_q <= term_q + LEN_WIDTH'(1);
                end
                if ((state_q == S_FEED || state_q == S_DRAIN) && pe_busy_i) begin
                    seen_busy_q <= 1'b1;
                end
                if (state_q == S_DRAIN) begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
                if (drain_ok) begin
                    result_q <= pe_mac_i;
                end
                if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // A reset cycle must never leak a PE command, even mid-job.
    assign pe_cmd_valid_o = cmd_valid & ~rst_i;
    assign pe_cmd_o       = cmd;
    assign op_ready_o     = ready;
    assign pe_param1_o    = DATA_WIDTH'(len_q);
    assign pe_preload_o   = preload_q;
    assign pe_data_o      = (state_q == S_FEED) ? op_data_i : '0;
    assign pe_weight_o    = (state_q == S_FEED) ? op_weight_i : '0;
    assign result_o       = result_q;
    assign done_o         = (state_q == S_DONE);
    assign err_o          = err_q;
    assign idle_o         = (state_q == S_IDLE);

endmodule
